// File: rtl/sdc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sdc_fifo_pkg
// Shared constants and helpers for the SD data-path FIFO controller.
//   - Default parameter values for the controller.
//   - fifo_depth(): number of RAM words for a given address width.
//   - ptr_width():  pointer width (address bits plus one wrap bit).
// ---------------------------------------------------------------------------
package sdc_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_AFULL_LEVEL = 12;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // The extra MSB is the wrap bit that tells a full FIFO from an empty one.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  localparam int unsigned DEPTH     = fifo_depth(DEF_ADDR_WIDTH);
  localparam int unsigned PTR_WIDTH = ptr_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/sdc_fifo_ptr.sv
// ---------------------------------------------------------------------------
// sdc_fifo_ptr
// One FIFO pointer register: increments by one when inc is high, clears to
// zero on flush (synchronous) or when rst_n is low (asynchronous).
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   synchronous clear, dominates inc
//   inc    in   advance the pointer by one
//   ptr    out  current pointer value (W bits, MSB is the wrap bit)
// ---------------------------------------------------------------------------
module sdc_fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr;
    if (flush) begin
      ptr_next = '0;
    end else if (inc) begin
      // Natural modulo-2**W roll-over carries the low bits into the wrap bit.
      ptr_next = ptr + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/sdc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sdc_fifo_ctrl
// Single-clock FIFO controller for an external true dual-port RAM whose
// port B read is registered (one cycle latency). Port A is write-only,
// port B is read-only. The pop side is first-word-fall-through.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   flush           synchronous clear of all pointers (RAM untouched)
//   wr_en, wr_data  push request and data; ignored while full
//   full            no space left
//   almost_full     fill_level >= AFULL_LEVEL
//   rd_en           pop request, honoured only while rd_valid
//   rd_data         head word (straight from ram_q_b)
//   rd_valid        rd_data holds a valid head word
//   fill_level      words written minus words popped (incl. not-yet-visible)
//   ram_adr_a/ram_d_a/ram_we_a   RAM write port
//   ram_adr_b/ram_q_b            RAM read port
// ---------------------------------------------------------------------------
module sdc_fifo_ctrl
  import sdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_LEVEL = DEF_AFULL_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int unsigned PW         = ptr_width(ADDR_WIDTH);
  localparam int unsigned FIFO_DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LEVEL);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_vis;
  logic          wr_fire;
  logic          rd_fire;

  // -------------------------------------------------------------------------
  // Pointers
  // -------------------------------------------------------------------------
  sdc_fifo_ptr #(.W(PW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (wr_fire),
    .ptr   (wptr)
  );

  sdc_fifo_ptr #(.W(PW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (rd_fire),
    .ptr   (rptr)
  );

  // wptr_vis lags wptr by one cycle, so a word written at edge t becomes
  // visible at t+2: by then the RAM has stored it and the registered read
  // of its address (issued in t+1) has returned it on ram_q_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_vis <= '0;
    end else if (flush) begin
      wptr_vis <= '0;
    end else begin
      wptr_vis <= wptr;
    end
  end

  // -------------------------------------------------------------------------
  // Flags (registers only)
  // -------------------------------------------------------------------------
  always_comb begin
    fill_level  = wptr - rptr;
    full        = (fill_level == DEPTH_P);
    almost_full = (fill_level >= AFULL_P);
    rd_valid    = (wptr_vis != rptr);
  end

  // -------------------------------------------------------------------------
  // Push / pop handshakes
  // -------------------------------------------------------------------------
  // rst_n gates the write strobe so no RAM write can slip out while the
  // pointers are being held in reset.
  always_comb begin
    wr_fire = wr_en & ~full & ~flush & rst_n;
    rd_fire = rd_en & rd_valid & ~flush;
  end

  // -------------------------------------------------------------------------
  // RAM ports
  // -------------------------------------------------------------------------
  always_comb begin
    ram_we_a  = wr_fire;
    ram_adr_a = wptr[ADDR_WIDTH-1:0];
    ram_d_a   = wr_data;
    // Read ahead: on a pop, address the next word now so it is on ram_q_b
    // in the following cycle, sustaining one word per cycle.
    ram_adr_b = rptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(rd_fire);
    rd_data   = ram_q_b;
  end

endmodule

// File: tb/tb_sdc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdc_fifo_ctrl
// Self-checking bench for sdc_fifo_ctrl with a behavioural RAM and a
// queue-based reference model of the FIFO.
// ---------------------------------------------------------------------------
module tb_sdc_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   fill_level;
  logic [AW-1:0] ram_adr_a;
  logic [DW-1:0] ram_d_a;
  logic          ram_we_a;
  logic [AW-1:0] ram_adr_b;
  logic [DW-1:0] ram_q_b;

  sdc_fifo_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fill_level  (fill_level),
    .ram_adr_a   (ram_adr_a),
    .ram_d_a     (ram_d_a),
    .ram_we_a    (ram_we_a),
    .ram_adr_b   (ram_adr_b),
    .ram_q_b     (ram_q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  // Reference model: queue of accepted words with the cycle they were taken.
  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } ent_t;

  ent_t q[$];
  int   cyc        = 0;
  int   push_total = 0;
  int   pop_total  = 0;
  int   n_checks   = 0;
  int   n_errors   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, then
  // advance the model with what the coming edge should do.
  task automatic do_cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    int   size;
    logic vis;
    logic acc;
    logic pop;
    @(posedge clk);
    #1;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    @(negedge clk);
    size = q.size();
    // A word becomes poppable two cycles after it was accepted.
    vis  = (size > 0) && (q[0].t <= cyc - 2);
    acc  = w && !f && (size < DEPTH);
    pop  = r && vis && !f;
    check("fill_level",  64'(fill_level),  64'(size));
    check("full",        64'(full),        64'(size == DEPTH));
    check("almost_full", 64'(almost_full), 64'(size >= AFULL));
    check("rd_valid",    64'(rd_valid),    64'(vis));
    check("ram_we_a",    64'(ram_we_a),    64'(acc));
    check("ram_adr_b",   64'(ram_adr_b),   64'((pop_total + (pop ? 1 : 0)) % DEPTH));
    if (acc) begin
      check("ram_adr_a", 64'(ram_adr_a), 64'(push_total % DEPTH));
      check("ram_d_a",   64'(ram_d_a),   64'(d));
    end
    if (vis) check("rd_data", 64'(rd_data), 64'(q[0].data));
    $display("cyc %0d wr=%0b rd=%0b fl=%0b d=%08h acc=%0b pop=%0b fill=%0d",
             cyc, w, r, f, d, acc, pop, size);
    if (f) begin
      q.delete();
      push_total = 0;
      pop_total  = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        pop_total++;
      end
      if (acc) begin
        q.push_back('{data: d, t: cyc});
        push_total++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, r, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fill",     64'(fill_level),  64'd0);
    check("rst_full",     64'(full),        64'd0);
    check("rst_afull",    64'(almost_full), 64'd0);
    check("rst_rd_valid", 64'(rd_valid),    64'd0);
    check("rst_we",       64'(ram_we_a),    64'd0);
    rst_n = 1'b1;

    // Single word latency with rd_en held high.
    do_cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Fill to full, one rejected push, then drain in order.
    for (int i = 0; i < 17; i++) do_cycle(1'b1, 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(18, 1'b1);

    // Full with simultaneous push and pop: pop wins, push rejected.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    do_cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idle(18, 1'b1);

    // Streaming at one word per cycle, wrapping the pointers.
    for (int i = 0; i < 40; i++) do_cycle(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
    idle(4, 1'b1);

    // Flush with a concurrent push; next push is the first word out.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    do_cycle(1'b1, 32'h3FF, 1'b0, 1'b1);
    idle(1, 1'b0);
    do_cycle(1'b1, 32'h4444_0000, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic w;
      logic r;
      logic f;
      w = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 59) == 0);
      do_cycle(w, $urandom, r, f);
    end

    // Asynchronous reset mid-burst with 7 words queued.
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    wr_en   = 1'b1;
    wr_data = 32'h5555_5555;
    rd_en   = 1'b1;
    flush   = 1'b0;
    #1;
    check("pre_rst_fill", 64'(fill_level), 64'd7);
    rst_n = 1'b0;
    #1;
    check("arst_fill",     64'(fill_level), 64'd0);
    check("arst_rd_valid", 64'(rd_valid),   64'd0);
    check("arst_we",       64'(ram_we_a),   64'd0);
    q.delete();
    push_total = 0;
    pop_total  = 0;
    @(negedge clk);
    check("arst_hold_fill", 64'(fill_level), 64'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b1, 32'h6666_0001, 1'b0, 1'b0);
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
